// File: rtl/rsa_modexp_avmm_if.sv
// rtl/rsa_modexp_avmm_if.sv - Avalon-MM slave bus bundle for the RSA modexp coprocessor
// Signals: avs_address[4:0] word address, avs_read/avs_write strobes,
//          avs_writedata[31:0], avs_readdata[31:0] (zero read latency), irq.
// Modports: slave = coprocessor side, master = bus host side.
interface rsa_modexp_avmm_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );
endinterface

// File: rtl/rsa_modexp_avmm.sv
// rtl/rsa_modexp_avmm.sv - RSA modular exponentiation coprocessor with Avalon-MM slave
// Computes msg^exp mod n by right-to-left square-and-multiply, each product done
// by a shift-add interleaved modular multiplier (one multiplier bit per clock).
// Ports: clk, reset (async, active-high), bus (rsa_modexp_avmm_if.slave).
// Registers: 0 CTRL {mode,irq_en,start}, 1 STATUS {error,done,busy}, 2 N, 3 E,
//            4 D, 5 MSG, 6 RESULT (ro), 7 CYCLES (ro).
module rsa_modexp_avmm #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             reset,
  rsa_modexp_avmm_if.slave bus
);
  localparam int KW = $clog2(W);

  typedef enum logic [2:0] {IDLE, CHECK, MUL, STEP, DONE} state_t;
  state_t state, state_nxt;

  logic          irq_en, mode, done, error, busy;
  logic [W-1:0]  n_reg, e_reg, d_reg, msg_reg, result;
  logic [31:0]   cycles, cyc_cnt;
  logic [W-1:0]  sn, sexp, acc, base;
  logic [W:0]    ra, rb;
  logic [KW-1:0] k, j;
  logic          start_ok, chk_fail;
  logic [31:0]   rdata;
  logic [31:0]   wd;
  logic          unused_wd;

  assign wd        = bus.avs_writedata;
  assign unused_wd = ^wd;
  assign busy      = (state != IDLE);
  assign start_ok  = bus.avs_write && (bus.avs_address == 5'h00) && wd[0] && !busy;
  assign chk_fail  = (sn < W'(2)) || (base >= sn);

  // One interleaved step: r = 2r mod m, then r = r + a mod m when the scanned
  // bit is set. Both partial sums stay below 2m, hence the extra headroom bit.
  function automatic logic [W:0] mm_step(input logic [W:0] r, input logic [W-1:0] a,
                                         input logic bit_set, input logic [W-1:0] m);
    logic [W+1:0] t;
    t = {r, 1'b0};
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    if (bit_set) begin
      t = t + {2'b00, a};
      if (t >= {2'b00, m}) t = t - {2'b00, m};
    end
    return t[W:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = CHECK;
      CHECK:   state_nxt = chk_fail ? DONE : MUL;
      MUL:     if (j == '0) state_nxt = STEP;
      STEP:    state_nxt = (k == KW'(W - 1)) ? DONE : MUL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en  <= 1'b0;
      mode    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      n_reg   <= '0;
      e_reg   <= '0;
      d_reg   <= '0;
      msg_reg <= '0;
      result  <= '0;
      cycles  <= '0;
      cyc_cnt <= '0;
      sn      <= '0;
      sexp    <= '0;
      acc     <= '0;
      base    <= '0;
      ra      <= '0;
      rb      <= '0;
      k       <= '0;
      j       <= '0;
    end else begin
      if (bus.avs_write) begin
        case (bus.avs_address)
          5'h00: begin
            irq_en <= wd[1];
            mode   <= wd[2];
          end
          5'h01: if (wd[1]) begin
            done  <= 1'b0;
            error <= 1'b0;
          end
          5'h02: if (!busy) n_reg   <= wd[W-1:0];
          5'h03: if (!busy) e_reg   <= wd[W-1:0];
          5'h04: if (!busy) d_reg   <= wd[W-1:0];
          5'h05: if (!busy) msg_reg <= wd[W-1:0];
          default: ;
        endcase
      end

      case (state)
        IDLE: if (start_ok) begin
          // Mode comes from the same CTRL write that carries the start bit.
          sn      <= n_reg;
          sexp    <= wd[2] ? d_reg : e_reg;
          base    <= msg_reg;
          done    <= 1'b0;
          error   <= 1'b0;
          cyc_cnt <= '0;
        end
        CHECK: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          acc     <= W'(1);
          ra      <= '0;
          rb      <= '0;
          j       <= KW'(W - 1);
          k       <= '0;
          if (chk_fail) error <= 1'b1;
        end
        MUL: begin
          // Both lanes scan base MSB first: lane A adds acc, lane B adds base.
          cyc_cnt <= cyc_cnt + 32'd1;
          ra      <= mm_step(ra, acc, base[j], sn);
          rb      <= mm_step(rb, base, base[j], sn);
          j       <= j - KW'(1);
        end
        STEP: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          if (sexp[k]) acc <= ra[W-1:0];
          base    <= rb[W-1:0];
          k       <= k + KW'(1);
          ra      <= '0;
          rb      <= '0;
          j       <= KW'(W - 1);
        end
        DONE: begin
          result <= error ? '0 : acc;
          cycles <= cyc_cnt + 32'd1;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.avs_read) begin
      case (bus.avs_address)
        5'h00:   rdata = {29'd0, mode, irq_en, 1'b0};
        5'h01:   rdata = {29'd0, error, done, busy};
        5'h02:   rdata = 32'(n_reg);
        5'h03:   rdata = 32'(e_reg);
        5'h04:   rdata = 32'(d_reg);
        5'h05:   rdata = 32'(msg_reg);
        5'h06:   rdata = 32'(result);
        5'h07:   rdata = cycles;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.avs_readdata = rdata;
  assign bus.irq          = done & irq_en;
endmodule

// File: doc/rsa_modexp_avmm.md
# rsa_modexp_avmm

Parametrised RSA modular-exponentiation coprocessor with an Avalon-MM slave. Software loads modulus, encryption/decryption exponents and message, then starts an encrypt or decrypt. The block computes result = msg^exp mod n with a shift-add interleaved modular multiplier, so no wide hardware multipliers are used. It sits on the HPS/Nios lightweight bus and raises an optional interrupt on completion.

## Interface
- W, default 32: operand width in bits; legal range 8..32.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- avs_address  in  5  word address.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  combinational read data (readLatency 0); reset/idle value 0.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- irq  out  1  equals STATUS.done AND CTRL.irq_en; reset value 0.

## Operation
- Register map:
  - 0x00 CTRL: bit0 start (write-1 pulse, reads 0); bit1 irq_en (R/W); bit2 mode (0 = use E, 1 = use D; R/W).
  - 0x01 STATUS: bit0 busy, bit1 done (sticky), bit2 error. Writing 1 to bit1 clears both done and error.
  - 0x02 N, 0x03 E, 0x04 D, 0x05 MSG: R/W.
  - 0x06 RESULT: read-only.
  - 0x07 CYCLES: read-only; clock count of the last operation.
  - Other addresses read 0 and ignore writes.
- Operand registers store bits [W-1:0] only; the upper bits read 0.
- Writes to 0x02–0x05 and start pulses while busy are ignored. CTRL.irq_en and mode writes are always accepted.
- FSM states: IDLE, CHECK, MUL, STEP, DONE.
  - IDLE: an accepted start snapshots N, MSG and the selected exponent, clears done/error, sets busy, goes to CHECK.
  - CHECK: if n < 2 or msg >= n, set error, RESULT = 0, go to DONE. Otherwise base = msg, acc = 1, bit index k = 0, go to MUL.
  - MUL: two parallel interleaved multipliers run for W cycles, scanning the multiplier operand MSB first.
    - Lane A computes acc*base mod n. Lane B computes base*base mod n.
    - Per cycle: r = 2r, subtract n if r >= n; then if bit set, r = r + a, subtract n if r >= n.
    - r is W+1 bits wide. Operands are always < n.
  - STEP (1 cycle): if exp[k], acc takes the lane A result; base always takes the lane B result. Then k = k+1. If k = W-1 was just processed, go to DONE, else go to MUL.
  - DONE (1 cycle): RESULT = acc (or 0 on error), CYCLES latched, busy = 0, done = 1, go to IDLE.
- All W exponent bits are always processed, giving constant time independent of exponent value.
- An exponent of 0 gives a result of 1.
- Reset mid-operation: FSM returns to IDLE; all registers, STATUS and RESULT clear to 0; irq = 0.

## Timing
- Start write accepted at edge T. busy reads 1 from T+1.
- Normal latency: done = 1 and RESULT valid at T + 2 + W*(W+1). For W=32 this is T+1058. CYCLES reads 2 + W*(W+1).
- Error latency: done = 1 at T+2, CYCLES = 2.
- busy and done are never both 1. irq follows done combinationally through irq_en.
- A start in the same cycle as a done-clear write is accepted, and the clear is applied first.
- avs_readdata is valid in the same cycle as avs_read, and is 0 when avs_read = 0.

## Test plan
- Encrypt, W=8: N=33, E=3, MSG=5, mode=0, start → RESULT=26, done at T+74, CYCLES=74, error=0.
- Decrypt, W=8: N=33, D=7, MSG=26, mode=1 → RESULT=5. Set irq_en=1 → irq=1; write STATUS=0x2 → irq=0, done=0.
- Boundaries, W=32:
  - N=15, E=17, MSG=5 → RESULT=5 at T+1058.
  - E=0 → RESULT=1.
  - N=0xFFFFFFFB, MSG=0xFFFFFFFA, E=2 → RESULT=1, checking the W+1-bit intermediate path.
- Error: N=33, MSG=40 → error=1, RESULT=0, done at T+2. Separately, N=1 → error=1.
- Busy protection: during an operation, write MSG=7 and start again → both ignored; the original result is produced; MSG still reads its old value.
- Reset mid-operation: assert reset 100 cycles after start → busy, done, irq, RESULT and N read 0. A new start after reset completes correctly.
